// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract pipeline: opcode encoding,
// default datapath width and small opcode helpers.
package addsub_pkg;

    // Default operand/result width in bits.
    localparam int DEFAULT_WIDTH = 32;

    // Opcode encoding as seen on in_op.
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ACC = 2'd2,
        OP_LDA = 2'd3
    } op_e;

    // True for the opcodes that write the internal accumulator.
    function automatic logic op_writes_acc(input op_e op);
        logic r;
        case (op)
            OP_ACC:  r = 1'b1;
            OP_LDA:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational add/subtract datapath: operand selection per opcode,
// carry/borrow, signed overflow detection and optional clamping.
// Clamping on signed overflow is built only when ADDSUB_PIPE_SAT_EN is
// defined; otherwise results wrap modulo 2^WIDTH.
module addsub_core
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_acc,
    output logic [WIDTH-1:0] o_s,
    output logic             o_c,
    output logic             o_v
);

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_sub;
    logic             w_pass;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_wrap;
    logic             w_ovf;
    logic             w_sign_diff;
    logic             w_res_flip;
`ifdef ADDSUB_PIPE_SAT_EN
    logic [WIDTH-1:0] w_smax;
    logic [WIDTH-1:0] w_smin;

    assign w_smax = {1'b0, {(WIDTH-1){1'b1}}};
    assign w_smin = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // Route operands: ACC adds A onto the accumulator, LDA bypasses the adder.
    always_comb begin
        w_x    = i_a;
        w_y    = i_b;
        w_sub  = 1'b0;
        w_pass = 1'b0;
        case (op_e'(i_op))
            OP_ADD: begin
                w_x = i_a;
                w_y = i_b;
            end
            OP_SUB: begin
                w_sub = 1'b1;
            end
            OP_ACC: begin
                w_x = i_acc;
                w_y = i_a;
            end
            OP_LDA: begin
                w_pass = 1'b1;
                w_y    = {WIDTH{1'b0}};
            end
            default: begin
                w_pass = 1'b1;
            end
        endcase
    end

    // One extra bit on the adder exposes carry-out (add) or borrow (sub).
    always_comb begin
        if (w_sub) begin
            w_ext = {1'b0, w_x} - {1'b0, w_y};
        end else begin
            w_ext = {1'b0, w_x} + {1'b0, w_y};
        end
    end

    assign w_wrap      = w_ext[WIDTH-1:0];
    assign w_sign_diff = w_x[WIDTH-1] ^ w_y[WIDTH-1];
    assign w_res_flip  = w_wrap[WIDTH-1] ^ w_x[WIDTH-1];

    // Signed overflow: result sign departs from the first operand when the
    // operands' signs make that impossible for an in-range result.
    always_comb begin
        if (w_pass) begin
            w_ovf = 1'b0;
        end else if (w_sub) begin
            w_ovf = w_sign_diff & w_res_flip;
        end else begin
            w_ovf = ~w_sign_diff & w_res_flip;
        end
    end

    // Final result select; the overflow direction follows the first operand's sign.
    always_comb begin
        o_s = w_wrap;
        o_c = w_ext[WIDTH];
        o_v = w_ovf;
        if (w_pass) begin
            o_s = i_a;
            o_c = 1'b0;
            o_v = 1'b0;
        end
`ifdef ADDSUB_PIPE_SAT_EN
        else if (w_ovf) begin
            o_s = w_x[WIDTH-1] ? w_smin : w_smax;
            o_c = w_ext[WIDTH];
            o_v = 1'b1;
        end
`endif
        else begin
            o_s = w_wrap;
            o_c = w_ext[WIDTH];
            o_v = w_ovf;
        end
    end

endmodule

// File: rtl/addsub_pipe.sv
// Single-stage add/subtract pipeline with valid/ready handshake,
// internal accumulator and sticky overflow flag.
// Optional feature: ADDSUB_PIPE_SAT_EN enables saturating results (in addsub_core).
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             out_v,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    logic             r_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_v;
    logic [WIDTH-1:0] r_acc;
    logic             r_sticky;

    logic             w_ready;
    logic             w_accept;
    logic             w_acc_we;
    logic [WIDTH-1:0] w_core_s;
    logic             w_core_c;
    logic             w_core_v;

    // Ready whenever the output slot is empty or being drained this cycle.
    assign w_ready  = ~r_valid | out_ready;
    assign w_accept = in_valid & w_ready;
    assign w_acc_we = w_accept & op_writes_acc(op_e'(in_op));

    addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_op  (in_op),
        .i_a   (in_a),
        .i_b   (in_b),
        .i_acc (r_acc),
        .o_s   (w_core_s),
        .o_c   (w_core_c),
        .o_v   (w_core_v)
    );

    // Output slot: capture on accept, drop on drain, otherwise hold steady.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_valid <= 1'b0;
            r_s     <= {WIDTH{1'b0}};
            r_c     <= 1'b0;
            r_v     <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_s     <= w_core_s;
            r_c     <= w_core_c;
            r_v     <= w_core_v;
        end else if (out_ready) begin
            r_valid <= 1'b0;
            r_s     <= r_s;
            r_c     <= r_c;
            r_v     <= r_v;
        end else begin
            r_valid <= r_valid;
            r_s     <= r_s;
            r_c     <= r_c;
            r_v     <= r_v;
        end
    end

    // Accumulator follows the (possibly clamped) result of accepted ACC/LDA.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_acc <= {WIDTH{1'b0}};
        end else if (w_acc_we) begin
            r_acc <= w_core_s;
        end else begin
            r_acc <= r_acc;
        end
    end

    // Sticky overflow: a new overflow takes priority over a clear request.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sticky <= 1'b0;
        end else if (w_accept && w_core_v) begin
            r_sticky <= 1'b1;
        end else if (ovf_clr) begin
            r_sticky <= 1'b0;
        end else begin
            r_sticky <= r_sticky;
        end
    end

    assign in_ready   = w_ready;
    assign out_valid  = r_valid;
    assign out_s      = r_s;
    assign out_c      = r_c;
    assign out_v      = r_v;
    assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe (WIDTH=32): directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_addsub_pipe;

    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = 2'd0;
    logic [W-1:0]  in_a = 32'd0;
    logic [W-1:0]  in_b = 32'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_s;
    logic          out_c;
    logic          out_v;
    logic          ovf_sticky;
    logic          ovf_clr = 1'b0;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    logic [W-1:0]  acc_m = 32'd0;
    logic          sticky_m = 1'b0;
    bit            rand_rdy = 1'b0;

    addsub_pipe #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s      (out_s),
        .out_c      (out_c),
        .out_v      (out_v),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: plain integer arithmetic on 64-bit values.
    task automatic predict(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output exp_t e);
        longint ux, uy, ur, sx, sy, sr;
        logic [W-1:0] x, y;
        e.s = 32'd0; e.c = 1'b0; e.v = 1'b0;
        if (op == 2'd3) begin
            e.s = a;
        end else begin
            x = (op == 2'd2) ? acc_m : a;
            y = (op == 2'd2) ? a : b;
            ux = longint'(x);
            uy = longint'(y);
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            if (op == 2'd1) begin
                ur  = ux - uy;
                sr  = sx - sy;
                e.c = (ux < uy);
            end else begin
                ur  = ux + uy;
                sr  = sx + sy;
                e.c = ((ur >> 32) != 64'd0);
            end
            e.s = ur[W-1:0];
            e.v = (sr > 64'sh7FFFFFFF) || (sr < -64'sh80000000);
`ifdef ADDSUB_PIPE_SAT_EN
            if (e.v) e.s = (sr > 64'sd0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
        end
        if (op == 2'd2 || op == 2'd3) acc_m = e.s;
        if (e.v) sticky_m = 1'b1;
        else if (ovf_clr) sticky_m = 1'b0;
    endtask

    // Present a request and hold it until the DUT takes it (bounded wait).
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        bit   took = 1'b0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        for (int n = 0; n < 200 && !took; n++) begin
            @(negedge CLK);
            if (in_ready) begin
                predict(op, a, b, e);
                sb.push_back(e);
                took = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        if (!took) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h00000000;
            1: return 32'hFFFFFFFF;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compare every cycle a result is shown; retire it on handshake.
    always @(negedge CLK) begin
        if (RST && out_valid) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_result actual=%0h required=none", out_s);
            end else begin
                chk("out_s", out_s, sb[0].s);
                chk("out_c", out_c, sb[0].c);
                chk("out_v", out_v, sb[0].v);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    // Random consumer back-pressure during the random phase.
    always @(posedge CLK) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1 RST = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_s", out_s, 32'd0);
        chk("rst_out_c", out_c, 1'b0);
        chk("rst_out_v", out_v, 1'b0);
        chk("rst_sticky", ovf_sticky, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge CLK); #1;
        RST = 1'b1;
        out_ready = 1'b1;

        // Carry-out and borrow corner cases
        issue(2'd0, 32'hFFFFFFFF, 32'h1);
        chk("add_wrap_s", out_s, 32'h0);
        chk("add_wrap_c", out_c, 1'b1);
        chk("add_wrap_v", out_v, 1'b0);
        issue(2'd1, 32'd5, 32'd7);
        chk("sub_borrow_s", out_s, 32'hFFFFFFFE);
        chk("sub_borrow_c", out_c, 1'b1);
        chk("sub_borrow_v", out_v, 1'b0);

        // Back-to-back accumulate
        issue(2'd3, 32'd10, 32'd0);
        chk("lda_s", out_s, 32'd10);
        issue(2'd2, 32'd5, 32'd0);
        chk("acc1_s", out_s, 32'd15);
        issue(2'd2, 32'd7, 32'd0);
        chk("acc2_s", out_s, 32'd22);

        // Asynchronous reset with a pending result and acc=22
        chk("pre_rst_valid", out_valid, 1'b1);
        RST = 1'b0;
        sb.delete();
        acc_m = 32'd0;
        sticky_m = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_s", out_s, 32'd0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        @(posedge CLK); #1;
        RST = 1'b1;
        issue(2'd2, 32'd3, 32'd0);
        chk("acc_after_rst_s", out_s, 32'd3);
        @(posedge CLK); #1;

        // Back-pressure with a second request pending
        out_ready = 1'b0;
        issue(2'd0, 32'd10, 32'd20);
        in_valid = 1'b1; in_op = 2'd0; in_a = 32'd1; in_b = 32'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_s", out_s, 32'd30);
            chk("stall_out_valid", out_valid, 1'b1);
            @(posedge CLK); #1;
        end
        out_ready = 1'b1;
        issue(2'd0, 32'd1, 32'd2);
        chk("after_stall_s", out_s, 32'd3);

        // Signed overflow and sticky flag
        issue(2'd0, 32'h7FFFFFFF, 32'h1);
        chk("ovf_v", out_v, 1'b1);
        chk("ovf_sticky", ovf_sticky, 1'b1);
`ifdef ADDSUB_PIPE_SAT_EN
        chk("ovf_s", out_s, 32'h7FFFFFFF);
`else
        chk("ovf_s", out_s, 32'h80000000);
`endif
        ovf_clr = 1'b1;
        issue(2'd0, 32'h7FFFFFFF, 32'h1);
        ovf_clr = 1'b0;
        chk("clr_vs_set_sticky", ovf_sticky, 1'b1);
        ovf_clr = 1'b1;
        @(posedge CLK); #1;
        ovf_clr = 1'b0;
        sticky_m = 1'b0;
        chk("clr_sticky", ovf_sticky, 1'b0);

        // Randomized traffic with random back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK); #1;
            end
            issue(2'($urandom_range(0, 3)), pick(), pick());
        end
        rand_rdy = 1'b0;
        @(posedge CLK); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(posedge CLK); #1;
        end
        chk("drain_empty", sb.size(), 0);
        chk("rand_sticky", ovf_sticky, sticky_m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 8..64).
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  reset, asynchronous and active-low (asserted at 0).
REQ-004 Port: in_valid  input  1  operation request valid.
REQ-005 Port: in_ready  output  1  block can accept a request this cycle.
REQ-006 Port: in_op  input  2  opcode: 0 ADD, 1 SUB, 2 ACC, 3 LDA.
REQ-007 Port: in_a  input  WIDTH  operand A.
REQ-008 Port: in_b  input  WIDTH  operand B; ignored for ACC and LDA.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: out_s  output  WIDTH  result.
REQ-012 Port: out_c  output  1  ADD/ACC: unsigned carry-out; SUB: unsigned borrow (A<B); LDA: 0.
REQ-013 Port: out_v  output  1  signed two's-complement overflow of the result; LDA: 0.
REQ-014 Port: ovf_sticky  output  1  set by any accepted overflowing operation, held until cleared.
REQ-015 Port: ovf_clr  input  1  synchronous clear of ovf_sticky.

Function
REQ-016 Accept = in_valid && in_ready; in_ready = !out_valid || out_ready (combinational; no bubble under continuous flow).
REQ-017 Latency: exactly 1 cycle; result registered on the accepting edge, out_valid high the following cycle.
REQ-018 out_valid set on accept; cleared when out_ready && !accept; stays high on simultaneous drain and accept.
REQ-019 While out_valid && !out_ready: out_s, out_c and out_v hold stable.
REQ-020 ADD: s = A+B; SUB: s = A-B; ACC: s = acc+A and acc <= s; LDA: s = A and acc <= A.
REQ-021 Internal accumulator acc is WIDTH bits; it changes only on accepted ACC/LDA.
REQ-022 Without saturation, arithmetic wraps modulo 2^WIDTH.
REQ-023 ovf_sticky: set on accept with v=1; ovf_clr clears it; set wins when both occur in the same cycle.
REQ-024 Inputs are ignored while in_ready=0 (no capture, no acc change).

Reset
REQ-025 While RST=0: out_valid=0, out_s=0, out_c=0, out_v=0, ovf_sticky=0, acc=0, effective immediately (asynchronous).
REQ-026 Reset mid-operation discards any pending result; in_ready=1 during and after reset.
REQ-027 Reset deassertion takes effect at the next CLK edge; the first accept can occur on that edge.

Configuration
REQ-028 Macro ADDSUB_PIPE_SAT_EN defined: on signed overflow, out_s clamps to the signed max (positive overflow) or signed min (negative); ACC stores the clamped value; out_v still reports 1.
REQ-029 Macro ADDSUB_PIPE_SAT_EN undefined: no clamping logic; results wrap per REQ-022.

Structure
REQ-030 Shared package addsub_pkg holds the opcode enum (ADD/SUB/ACC/LDA codes) and the default WIDTH constant.
REQ-031 Sub-module addsub_core holds the combinational compute (op select, carry/borrow, overflow, optional clamp); addsub_pipe holds the handshake register, acc and sticky flag.

Verification (WIDTH=32)
REQ-032 ADD 0xFFFFFFFF+0x1 -> next cycle out_s=0, out_c=1, out_v=0.
REQ-033 SUB 5-7 -> out_s=0xFFFFFFFE, out_c=1, out_v=0.
REQ-034 LDA 10, ACC 5, ACC 7 back-to-back with out_ready=1 -> out_s 10, 15, 22 on consecutive cycles.
REQ-035 ADD 10+20, then out_ready=0 for 3 cycles with a second request pending -> in_ready=0 and out_s=30 held; on out_ready=1, 30 is drained and the second request accepted on the same edge.
REQ-036 ADD 0x7FFFFFFF+1 -> out_v=1, ovf_sticky=1; out_s=0x80000000 (macro off) or 0x7FFFFFFF (macro on); ovf_clr with a simultaneous overflow -> sticky stays 1.
REQ-037 RST=0 asserted while out_valid=1 and acc=22 -> out_valid=0 and acc=0 immediately; after release, ACC 3 -> out_s=3.
